// File: rtl/sudoku_pkg.sv
// Shared constants for the 4x4 Sudoku board datapath: geometry, FSM encodings,
// the fixed solution used for hints, and the scan-group cell selection.
package sudoku_pkg;

  localparam int BOX  = 2;
  localparam int GRID = BOX * BOX;
  localparam int VW   = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [VW-1:0] SOLN [16] = '{
    3'd1, 3'd2, 3'd3, 3'd4,
    3'd3, 3'd4, 3'd1, 3'd2,
    3'd2, 3'd1, 3'd4, 3'd3,
    3'd4, 3'd3, 3'd2, 3'd1
  };

  // Cell index {row,col} of member k of group g: 0..3 rows, 4..7 cols, 8..11 boxes.
  function automatic logic [3:0] grp_cell(input logic [3:0] g, input logic [1:0] k);
    logic [1:0] r;
    logic [1:0] c;
    if (g < 4'd4) begin
      r = g[1:0];
      c = k;
    end else if (g < 4'd8) begin
      r = k;
      c = g[1:0];
    end else begin
      r = {g[1], k[1]};
      c = {g[0], k[0]};
    end
    return {r, c};
  endfunction

endpackage

// File: rtl/sudoku_board_dp_if.sv
// Control/data bundle between the game FSM / display and the board datapath.
interface sudoku_board_dp_if;
  import sudoku_pkg::*;

  logic          hint_load;
  logic [7:0]    fill_flag;
  logic          wr_en;
  logic [1:0]    wr_row;
  logic [1:0]    wr_col;
  logic [VW-1:0] wr_val;
  logic          check;
  logic [1:0]    rd_row;
  logic [1:0]    rd_col;
  logic [VW-1:0] rd_val;
  logic          busy;
  logic          done;
  logic          solved;
  logic          wr_rej;

  modport master (
    output hint_load, fill_flag, wr_en, wr_row, wr_col, wr_val, check, rd_row, rd_col,
    input  rd_val, busy, done, solved, wr_rej
  );

  modport slave (
    input  hint_load, fill_flag, wr_en, wr_row, wr_col, wr_val, check, rd_row, rd_col,
    output rd_val, busy, done, solved, wr_rej
  );

endinterface

// File: rtl/sudoku_group_chk.sv
// Combinational check of one row/col/box: fails on an empty cell, an
// out-of-range value, or any repeated digit.
module sudoku_group_chk
  import sudoku_pkg::*;
(
  input  logic [3:0][VW-1:0] vals,
  output logic               fail
);

  logic [GRID-1:0] seen_s;
  logic [GRID-1:0] oh_s;

  // Accumulate a one-hot seen mask and flag any collision.
  always_comb begin
    seen_s = '0;
    oh_s   = '0;
    fail   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((vals[k] == '0) || (vals[k] > VW'(GRID))) begin
        fail = 1'b1;
      end else begin
        oh_s = GRID'(1) << (vals[k] - 3'd1);
        if (|(seen_s & oh_s)) begin
          fail = 1'b1;
        end else begin
          seen_s = seen_s | oh_s;
        end
      end
    end
  end

endmodule

// File: rtl/sudoku_board_dp.sv
// 4x4 Sudoku board: hint loading, guarded player writes, and a 12-cycle
// row/col/box scan that reports done/solved back to the game FSM.
module sudoku_board_dp
  import sudoku_pkg::*;
(
  input logic              clka,
  input logic              restart,
  sudoku_board_dp_if.slave bus
);

  logic [VW-1:0]     cell_r [16];
  logic [15:0]       lock_r;
  logic [1:0]        state_r;
  logic [3:0]        gidx_r;
  logic              fail_r;
  logic              busy_r;
  logic              done_r;
  logic              solved_r;
  logic              wr_rej_r;

  logic [3:0]        waddr_s;
  logic              wr_ok_s;
  logic [3:0][VW-1:0] grp_vals_s;
  logic              grp_fail_s;

  assign waddr_s    = {bus.wr_row, bus.wr_col};
  assign bus.rd_val = cell_r[{bus.rd_row, bus.rd_col}];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.solved = solved_r;
  assign bus.wr_rej = wr_rej_r;

  // Write is legal only to an unlocked cell with an in-range value.
  always_comb begin
    if (!lock_r[waddr_s] && (bus.wr_val <= VW'(GRID))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Gather the four cells of the group currently being scanned.
  always_comb begin
    grp_vals_s = '0;
    for (int k = 0; k < 4; k++) begin
      grp_vals_s[k] = cell_r[grp_cell(gidx_r, k[1:0])];
    end
  end

  sudoku_group_chk u_chk (
    .vals (grp_vals_s),
    .fail (grp_fail_s)
  );

  // Board storage, scan FSM and registered status outputs.
  always_ff @(posedge clka) begin
    if (restart) begin
      for (int i = 0; i < 16; i++) begin
        cell_r[i] <= '0;
      end
      lock_r   <= 16'h0000;
      state_r  <= S_IDLE;
      gidx_r   <= 4'd0;
      fail_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      solved_r <= 1'b0;
      wr_rej_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      wr_rej_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.hint_load) begin
            for (int i = 0; i < 8; i++) begin
              cell_r[i] <= bus.fill_flag[i] ? SOLN[i] : '0;
            end
            for (int i = 8; i < 16; i++) begin
              cell_r[i] <= '0;
            end
            lock_r   <= {8'h00, bus.fill_flag};
            solved_r <= 1'b0;
          end else if (bus.wr_en) begin
            if (wr_ok_s) begin
              cell_r[waddr_s] <= bus.wr_val;
            end else begin
              wr_rej_r <= 1'b1;
            end
          end else begin
            wr_rej_r <= 1'b0;
          end
          if (bus.check) begin
            state_r  <= S_SCAN;
            gidx_r   <= 4'd0;
            fail_r   <= 1'b0;
            busy_r   <= 1'b1;
            solved_r <= 1'b0;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_SCAN: begin
          fail_r   <= fail_r | grp_fail_s;
          wr_rej_r <= bus.wr_en;
          if (gidx_r >= 4'd11) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
          end else begin
            gidx_r  <= gidx_r + 4'd1;
          end
        end
        S_DONE: begin
          done_r   <= 1'b1;
          solved_r <= ~fail_r;
          wr_rej_r <= bus.wr_en;
          state_r  <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_board_dp.sv
// Directed self-checking bench for sudoku_board_dp: hints, write guarding,
// scan latency/result, ignored re-check, mid-scan restart, write+check overlap.
module tb_sudoku_board_dp;

  logic clk = 1'b0;
  logic restart;
  always #5 clk = ~clk;

  sudoku_board_dp_if bus ();

  sudoku_board_dp dut (
    .clka    (clk),
    .restart (restart),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] soln_tb [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic load(input logic [7:0] ff);
    bus.hint_load = 1'b1;
    bus.fill_flag = ff;
    tick();
    bus.hint_load = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input int v);
    bus.wr_en  = 1'b1;
    bus.wr_row = 2'(r);
    bus.wr_col = 2'(c);
    bus.wr_val = 3'(v);
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output int v);
    bus.rd_row = 2'(r);
    bus.rd_col = 2'(c);
    #1;
    v = int'(bus.rd_val);
  endtask

  // Write solution values into rows 2-3, skipping cell index skip (16 = none).
  task automatic fill_low(input int skip);
    for (int i = 8; i < 16; i++) begin
      if (i != skip) wr(i / 4, i % 4, int'(soln_tb[i]));
    end
  endtask

  task automatic run_check(input int second_at, output int busy_cnt, output int done_at,
                           output int done_cnt, output int solved_v);
    bus.check = 1'b1;
    tick();
    bus.check = 1'b0;
    bus.wr_en = 1'b0;
    busy_cnt = int'(bus.busy);
    done_at  = 0;
    done_cnt = 0;
    solved_v = 0;
    for (int n = 1; n <= 20; n++) begin
      bus.check = (n == second_at);
      tick();
      bus.check = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        solved_v = int'(bus.solved);
      end
    end
  endtask

  int b, da, dc, sv, v;

  initial begin
    soln_tb = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd2,
                3'd2, 3'd1, 3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};
    restart       = 1'b1;
    bus.hint_load = 1'b0;
    bus.fill_flag = 8'h00;
    bus.wr_en     = 1'b0;
    bus.wr_row    = 2'd0;
    bus.wr_col    = 2'd0;
    bus.wr_val    = 3'd0;
    bus.check     = 1'b0;
    bus.rd_row    = 2'd0;
    bus.rd_col    = 2'd0;

    // Reset state
    do_restart();
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_solved", bus.solved, 0);
    check_val("rst_wr_rej", bus.wr_rej, 0);
    rd(1, 2, v); check_val("rst_cell12", v, 0);

    // T1: full correct board
    load(8'hFF);
    rd(1, 1, v); check_val("t1_hint11", v, 4);
    fill_low(16);
    check_val("t1_wr_rej", bus.wr_rej, 0);
    rd(3, 2, v); check_val("t1_cell32", v, 2);
    run_check(0, b, da, dc, sv);
    check_val("t1_busy_cycles", b, 12);
    check_val("t1_done_at", da, 13);
    check_val("t1_done_cnt", dc, 1);
    check_val("t1_solved", sv, 1);
    check_val("t1_solved_held", bus.solved, 1);

    // T2: duplicate at (3,3)
    wr(3, 3, 2);
    check_val("t2_wr_rej", bus.wr_rej, 0);
    run_check(0, b, da, dc, sv);
    check_val("t2_done_at", da, 13);
    check_val("t2_solved", sv, 0);

    // hint_load clears a held pass
    fill_low(16);
    run_check(0, b, da, dc, sv);
    check_val("hl_pre_solved", sv, 1);
    load(8'hFF);
    check_val("hl_clears_solved", bus.solved, 0);

    // T3: locked cell and out-of-range value
    do_restart();
    load(8'h0F);
    wr(0, 0, 4);
    check_val("t3_locked_rej", bus.wr_rej, 1);
    rd(0, 0, v); check_val("t3_locked_keep", v, 1);
    wr(2, 2, 5);
    check_val("t3_range_rej", bus.wr_rej, 1);
    rd(2, 2, v); check_val("t3_range_keep", v, 0);
    tick();
    check_val("t3_rej_pulse", bus.wr_rej, 0);
    wr(1, 0, 3);
    check_val("t3_ok_rej", bus.wr_rej, 0);
    rd(1, 0, v); check_val("t3_ok_val", v, 3);
    wr(1, 0, 0);
    rd(1, 0, v); check_val("t3_clear", v, 0);

    // T4: (1,1) empty, second check while busy ignored
    load(8'hDF);
    fill_low(16);
    rd(1, 1, v); check_val("t4_empty11", v, 0);
    run_check(5, b, da, dc, sv);
    check_val("t4_done_at", da, 13);
    check_val("t4_done_cnt", dc, 1);
    check_val("t4_solved", sv, 0);

    // T5: restart mid-scan, plus a write during scan is rejected
    load(8'hFF);
    fill_low(16);
    bus.check = 1'b1;
    tick();
    bus.check = 1'b0;
    wr(2, 0, 3);
    check_val("t5_scan_wr_rej", bus.wr_rej, 1);
    rd(2, 0, v); check_val("t5_scan_wr_keep", v, 2);
    for (int n = 0; n < 4; n++) tick();
    check_val("t5_busy_before", bus.busy, 1);
    do_restart();
    check_val("t5_busy_after", bus.busy, 0);
    dc = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (bus.done) dc++;
    end
    check_val("t5_no_done", dc, 0);
    check_val("t5_solved", bus.solved, 0);
    for (int i = 0; i < 16; i++) begin
      rd(i / 4, i % 4, v);
      check_val($sformatf("t5_cell%0d", i), v, 0);
    end

    // T6: write completing the board in the same cycle as check
    load(8'hFF);
    fill_low(8);
    rd(2, 0, v); check_val("t6_pre_empty", v, 0);
    bus.wr_en  = 1'b1;
    bus.wr_row = 2'd2;
    bus.wr_col = 2'd0;
    bus.wr_val = 3'd2;
    run_check(0, b, da, dc, sv);
    check_val("t6_done_at", da, 13);
    check_val("t6_solved", sv, 1);
    rd(2, 0, v); check_val("t6_cell20", v, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
